maku_uart_rx: RTL and testbench
===============================

// Module: maku_uart_rx
// PURPOSE
//  Peripheral-side UART receiver for the MAKu MCU: the far end of the serial line a host or bench drives onto uart_rx.
//  Oversamples the line and frames 8N1 bytes (LSB first).
//  Buffers received bytes in a small FIFO, drained by the core bus via a valid/ready handshake.
//  Raises a level interrupt while data is pending, and sticky framing and overrun error flags.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  input clock frequency
//  BAUD_RATE    115_200      line bit rate
//  OVERSAMPLE   16           sample ticks per bit (even, >=8)
//  FIFO_DEPTH   8            RX buffer entries (power of 2, >=2)
// PORTS
//  sys_clk_100mhz  in   1                      single clock domain; all logic on rising edge
//  sys_rst         in   1                      asynchronous, active-high reset
//  uart_rx         in   1                      serial input, idle high, asynchronous to clock
//  rx_data         out  8                      FIFO head byte; valid when rx_valid=1
//  rx_valid        out  1                      FIFO not empty
//  rx_ready        in   1                      consumer pops head when rx_valid & rx_ready
//  rx_irq          out  1                      level interrupt, equal to rx_valid
//  frame_err       out  1                      sticky: stop bit sampled low
//  overrun_err     out  1                      sticky: byte arrived while FIFO full
//  err_clr         in   1                      one-cycle pulse; clears both sticky flags
//  rx_busy         out  1                      state machine not in IDLE
//  fifo_count      out  $clog2(FIFO_DEPTH+1)   current FIFO occupancy
// BEHAVIOUR
//  Reset values
//   - All outputs 0 except rx_data=8'h00.
//   - Synchronizer flops reset to 1 (idle line); FIFO empty; FSM in IDLE.
//  Input path and tick
//   - uart_rx passes through a 2-FF synchronizer; the FSM sees it 2 cycles late.
//   - Tick divisor DIV = round(CLK_FREQ_HZ/(BAUD_RATE*OVERSAMPLE)); default 54, i.e. 540 ns per tick.
//   - The tick counter runs only outside IDLE and restarts at 0 on the start-edge detect.
//  FSM states (sample counter s counts ticks; bit counter b counts data bits)
//   - IDLE: falling edge on the synced line -> START, with s=0.
//   - START: at s=OVERSAMPLE/2-1 (mid start bit), line low -> DATA; line high -> IDLE (glitch rejected, no flags).
//   - DATA: every OVERSAMPLE ticks, sample the line and shift it into shreg[7] (LSB first).
//     After the 8th bit -> STOP.
//   - STOP: sample OVERSAMPLE ticks after the last data bit.
//     Line high -> push shreg, go to IDLE.
//     Line low -> discard byte, set frame_err, go to WAIT_IDLE.
//   - WAIT_IDLE: stay until the synced line is high, then IDLE. This absorbs break conditions without false starts.
//  Push and flag timing
//   - Push takes effect the cycle after the stop sample: rx_valid and fifo_count update then.
//   - Push with FIFO full (and no simultaneous pop): byte dropped, overrun_err set, FIFO contents unchanged.
//   - Push and pop in the same cycle when full: both are accepted and the count stays at FIFO_DEPTH.
//   - Push and pop in the same cycle when empty: the pop is ignored (rx_valid was 0) and the count becomes 1.
//   - Set beats clear: an err_clr in the same cycle a flag sets leaves that flag set.
//  Handshake and interrupt
//   - rx_data is the registered head and changes only on a pop or on a push into an empty FIFO.
//   - rx_irq is combinationally equal to rx_valid.
//  Arithmetic
//   - FIFO pointers are $clog2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH.
//   - full = MSBs differ and LSBs equal; empty = pointers equal.
//  Reset mid-frame: async clear of everything; a partial byte is lost with no flags.
// STRUCTURE
//  maku_uart_pkg (shared)
//   - rx_state_t enum {IDLE, START, DATA, STOP, WAIT_IDLE}.
//   - function calc_div(clk, baud, os) returning the rounded divisor.
//   - localparam UART_DATA_BITS=8.
//  Sub-module maku_sync_fifo #(WIDTH,DEPTH): push/pop/full/empty/count, first-word-fall-through head register.
//   - The FSM, synchronizer and tick counter stay in maku_uart_rx.
// TESTING
//  1. Reset, line idle 10 us -> rx_valid=0, rx_busy=0, all flags 0.
//  2. Send 0xA5 at 8680 ns per bit, 1 start/8 data/1 stop, rx_ready=0
//     -> rx_data=8'hA5, rx_valid=1, rx_irq=1, fifo_count=1.
//     Then pulse rx_ready for one cycle -> rx_valid=0 next cycle.
//  3. Low pulse of 2 us on uart_rx -> glitch rejected: no push, flags 0, FSM back in IDLE.
//  4. Send 0x3C with the stop bit held low, then idle
//     -> no push, frame_err=1, passes through WAIT_IDLE.
//     Then pulse err_clr -> frame_err=0.
//  5. With rx_ready=0, send 9 bytes 0x00..0x08
//     -> fifo_count=8, overrun_err=1, drained order 0x00..0x07.
//  6. Assert sys_rst in the middle of bit 4 of 0xFF, release, then send 0x5A
//     -> only 0x5A is received, no flags.

Source files
------------

// File: rtl/maku_uart_pkg.sv
// MAKu UART shared types and helpers.
// Receiver state encoding and baud divisor arithmetic.
`timescale 1ns/1ps
package maku_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    function automatic int calc_div(input int clk, input int baud, input int os);
        return (clk + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/maku_sync_fifo.sv
// Synchronous FIFO with a registered first-word-fall-through head.
// Full accepts a push only when a pop happens in the same cycle.
`timescale 1ns/1ps
module maku_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       empty_o,
    output logic                       overflow_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q;
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    rd_nxt;
    logic [PW-1:0]    cnt;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full       = (wr_q[AW] != rd_q[AW]) &&
                        (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o    = (wr_q == rd_q);
    assign pop_ok     = pop_i && !empty_o;
    assign push_ok    = push_i && (!full || pop_ok);
    assign overflow_o = push_i && full && !pop_ok;
    assign rd_nxt     = rd_q + 1'b1;
    assign cnt        = wr_q - rd_q;
    assign count_o    = cnt;
    assign head_o     = head_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_nxt;
            // Incoming byte becomes head when nothing older will remain
            if (push_ok && (empty_o || (pop_ok && cnt == PW'(1)))) begin
                head_q <= din_i;
            end else if (pop_ok) begin
                head_q <= mem_q[rd_nxt[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/maku_uart_rx.sv
// MAKu peripheral UART receiver: 8N1 framing with oversampling,
// buffered bytes, level interrupt and sticky error flags.
`timescale 1ns/1ps
module maku_uart_rx
    import maku_uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                            sys_clk_100mhz,
    input  logic                            sys_rst,
    input  logic                            uart_rx,
    output logic [UART_DATA_BITS-1:0]       rx_data,
    output logic                            rx_valid,
    input  logic                            rx_ready,
    output logic                            rx_irq,
    output logic                            frame_err,
    output logic                            overrun_err,
    input  logic                            err_clr,
    output logic                            rx_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
    localparam int TW  = $clog2(DIV + 1);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(UART_DATA_BITS);

    rx_state_t               state_q, state_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic [SW-1:0]           s_q, s_d;
    logic [BW-1:0]           b_q, b_d;
    logic [UART_DATA_BITS-1:0] sh_q, sh_d;
    logic                    sync1_q, sync2_q, prev_q;
    logic                    ferr_q, ferr_d;
    logic                    oerr_q, oerr_d;
    logic                    line;
    logic                    tick;
    logic                    push;
    logic                    ferr_set;
    logic                    overflow;
    logic                    empty;

    assign line = sync2_q;
    assign tick = (state_q != IDLE) && (tick_q == TW'(DIV - 1));

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        b_d      = b_q;
        sh_d     = sh_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        tick_d   = (state_q == IDLE || tick) ? '0 : tick_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (prev_q && !line) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == SW'(OVERSAMPLE / 2 - 1)) begin
                        s_d     = '0;
                        b_d     = '0;
                        state_d = line ? IDLE : DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == SW'(OVERSAMPLE - 1)) begin
                        s_d  = '0;
                        sh_d = {line, sh_q[UART_DATA_BITS-1:1]};
                        b_d  = b_q + 1'b1;
                        if (b_q == BW'(UART_DATA_BITS - 1)) state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == SW'(OVERSAMPLE - 1)) begin
                        s_d = '0;
                        if (line) begin
                            push    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_set = 1'b1;
                            state_d  = WAIT_IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            WAIT_IDLE: begin
                if (line) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A new error in the same cycle as err_clr wins
    assign ferr_d = ferr_set || (ferr_q && !err_clr);
    assign oerr_d = overflow || (oerr_q && !err_clr);

    always_ff @(posedge sys_clk_100mhz or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            tick_q  <= '0;
            s_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            tick_q  <= tick_d;
            s_q     <= s_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    maku_sync_fifo #(
        .WIDTH(UART_DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (sys_clk_100mhz),
        .rst_i      (sys_rst),
        .push_i     (push),
        .din_i      (sh_d),
        .pop_i      (rx_ready),
        .head_o     (rx_data),
        .empty_o    (empty),
        .overflow_o (overflow),
        .count_o    (fifo_count)
    );

    assign rx_valid    = !empty;
    assign rx_irq      = rx_valid;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_maku_uart_rx.sv
// Bench for maku_uart_rx: drives serial frames and checks
// the buffered bytes and flags against a queue model.
`timescale 1ns/1ps
module tb_maku_uart_rx;

    localparam int BIT_NS = 8680;
    localparam int DEPTH  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rdy = 1'b0;
    logic       eclr = 1'b0;
    logic [7:0] data;
    logic       valid, irq, ferr, oerr, busy;
    logic [3:0] cnt;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] mq[$];
    bit         m_ferr = 1'b0;
    bit         m_oerr = 1'b0;

    always #5 clk = ~clk;

    maku_uart_rx dut (
        .sys_clk_100mhz (clk),
        .sys_rst        (rst),
        .uart_rx        (rxd),
        .rx_data        (data),
        .rx_valid       (valid),
        .rx_ready       (rdy),
        .rx_irq         (irq),
        .frame_err      (ferr),
        .overrun_err    (oerr),
        .err_clr        (eclr),
        .rx_busy        (busy),
        .fifo_count     (cnt)
    );

    task automatic model_rx(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) m_ferr = 1'b1;
        else if (mq.size() == DEPTH) m_oerr = 1'b1;
        else mq.push_back(b);
    endtask

    task automatic send_head(input logic [7:0] b);
        rxd = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            #BIT_NS;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_head(b);
        rxd = 1'b1;
        #BIT_NS;
        #BIT_NS;
        model_rx(b, 1'b1);
    endtask

    task automatic pop_one(input string tag);
        @(negedge clk);
        compared++;
        if (valid !== 1'b1 || data !== mq[0]) begin
            mismatched++;
            $display("FAIL %s_pop got valid=%b data=%h want valid=1 data=%h",
                     tag, valid, data, mq[0]);
        end
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        void'(mq.pop_front());
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #10000;
        @(negedge clk);
        compared++;
        if ({valid, irq, busy, ferr, oerr} !== 5'b0 || cnt !== 4'd0 ||
            data !== 8'h00) begin
            mismatched++;
            $display("FAIL reset got v=%b i=%b b=%b fe=%b oe=%b c=%0d d=%h want all 0",
                     valid, irq, busy, ferr, oerr, cnt, data);
        end
    endtask

    task automatic test_single();
        send_byte(8'hA5);
        @(negedge clk);
        compared++;
        if (data !== 8'hA5 || valid !== 1'b1 || irq !== 1'b1 ||
            cnt !== 4'd1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL single got d=%h v=%b i=%b c=%0d b=%b want d=a5 v=1 i=1 c=1 b=0",
                     data, valid, irq, cnt, busy);
        end
        rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
        void'(mq.pop_front());
        compared++;
        if (valid !== 1'b0 || irq !== 1'b0 || cnt !== 4'd0) begin
            mismatched++;
            $display("FAIL single_pop got v=%b i=%b c=%0d want 0 0 0",
                     valid, irq, cnt);
        end
    endtask

    task automatic test_glitch();
        rxd = 1'b0;
        #2000;
        rxd = 1'b1;
        #10000;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || valid !== 1'b0 || ferr !== 1'b0 || oerr !== 1'b0) begin
            mismatched++;
            $display("FAIL glitch got b=%b v=%b fe=%b oe=%b want 0 0 0 0",
                     busy, valid, ferr, oerr);
        end
    endtask

    task automatic test_frame_err();
        send_head(8'h3C);
        rxd = 1'b0;
        #BIT_NS;
        #BIT_NS;
        m_ferr = 1'b1;
        @(negedge clk);
        compared++;
        if (busy !== 1'b1 || ferr !== 1'b1 || valid !== 1'b0) begin
            mismatched++;
            $display("FAIL ferr_wait got b=%b fe=%b v=%b want 1 1 0",
                     busy, ferr, valid);
        end
        rxd = 1'b1;
        #BIT_NS;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || cnt !== 4'd0 || ferr !== m_ferr) begin
            mismatched++;
            $display("FAIL ferr_idle got b=%b c=%0d fe=%b want 0 0 1",
                     busy, cnt, ferr);
        end
        eclr = 1'b1;
        @(negedge clk);
        eclr = 1'b0;
        m_ferr = 1'b0;
        compared++;
        if (ferr !== m_ferr || oerr !== 1'b0) begin
            mismatched++;
            $display("FAIL ferr_clr got fe=%b oe=%b want 0 0", ferr, oerr);
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < 9; i++) send_byte(8'(i));
        @(negedge clk);
        compared++;
        if (cnt !== 4'(mq.size()) || oerr !== m_oerr || m_oerr !== 1'b1) begin
            mismatched++;
            $display("FAIL overrun got c=%0d oe=%b want c=%0d oe=1",
                     cnt, oerr, mq.size());
        end
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (mq[0] !== 8'(i)) begin
                mismatched++;
                $display("FAIL overrun_model got %h want %h", mq[0], 8'(i));
            end
            pop_one("overrun");
        end
        @(negedge clk);
        compared++;
        if (valid !== 1'b0 || cnt !== 4'd0) begin
            mismatched++;
            $display("FAIL overrun_empty got v=%b c=%0d want 0 0", valid, cnt);
        end
        eclr = 1'b1;
        @(negedge clk);
        eclr = 1'b0;
        m_oerr = 1'b0;
        compared++;
        if (oerr !== m_oerr) begin
            mismatched++;
            $display("FAIL overrun_clr got %b want 0", oerr);
        end
    endtask

    task automatic test_mid_reset();
        rxd = 1'b0;
        #BIT_NS;
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            #BIT_NS;
        end
        rxd = 1'b1;
        #(BIT_NS / 2);
        rst = 1'b1;
        #1;
        compared++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            mismatched++;
            $display("FAIL midrst_async got b=%b v=%b want 0 0", busy, valid);
        end
        #200;
        rst = 1'b0;
        mq.delete();
        m_ferr = 1'b0;
        m_oerr = 1'b0;
        #(BIT_NS * 5);
        send_byte(8'h5A);
        @(negedge clk);
        compared++;
        if (cnt !== 4'(mq.size()) || ferr !== m_ferr || oerr !== m_oerr) begin
            mismatched++;
            $display("FAIL midrst got c=%0d fe=%b oe=%b want c=%0d fe=0 oe=0",
                     cnt, ferr, oerr, mq.size());
        end
        pop_one("midrst");
    endtask

    task automatic test_random();
        logic [7:0] b;
        int n;
        for (int it = 0; it < 16; it++) begin
            b = 8'($urandom);
            send_byte(b);
            @(negedge clk);
            compared++;
            if (cnt !== 4'(mq.size()) || valid !== (mq.size() != 0) ||
                irq !== valid || oerr !== m_oerr || ferr !== m_ferr) begin
                mismatched++;
                $display("FAIL rand_state got c=%0d v=%b i=%b oe=%b fe=%b want c=%0d oe=%b fe=%b",
                         cnt, valid, irq, oerr, ferr, mq.size(), m_oerr, m_ferr);
            end
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                if (mq.size() != 0) pop_one("rand");
            end
        end
        while (mq.size() != 0) pop_one("rand_drain");
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
